// File: rtl/ps2_keyboard_host.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_host
// Purpose  : PS/2 keyboard host for the memory-mapped I/O bus.
//            - Receives 11-bit device frames and checks start, odd parity
//              and stop bits.
//            - Folds E0 (extended) and F0 (break) prefixes into single
//              10-bit key events.
//            - Buffers events in a FIFO with a threshold interrupt and a
//              sticky overflow flag.
//            - Sends host-to-device command bytes (LEDs, configuration)
//              over the open-drain clock and data lines.
// Ports    : clk_i, reset_ni              clock, async active-low reset
//            ps2_clk_async_i/_data_async_i  raw PS/2 pin levels
//            ps2_clk_oe_o/_data_oe_o      1 = pull the line low
//            read_enable_i, read_data_o,
//            read_valid_o                 event FIFO pop interface
//            interrupt_o, overflow_o      FIFO status
//            rx_error_o, tx_error_o       one-cycle error pulses
//            cmd_valid_i, cmd_data_i,
//            cmd_ready_o                  command byte handshake
// Revision : 1.0  initial release
// ============================================================================
module ps2_keyboard_host #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int IRQ_THRESHOLD  = 1
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       ps2_clk_async_i,
    input  logic       ps2_data_async_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    input  logic       read_enable_i,
    output logic [9:0] read_data_o,
    output logic       read_valid_o,
    output logic       interrupt_o,
    output logic       overflow_o,
    output logic       rx_error_o,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    output logic       tx_error_o
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_INH_LAST = c_CW'(INHIBIT_CYCLES - 1);
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_IRQ_TH   = (c_AW+1)'(IRQ_THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_RX           = 3'd1,
        S_TX_INHIBIT   = 3'd2,
        S_TX_START     = 3'd3,
        S_TX_BITS      = 3'd4,
        S_TX_ACK       = 3'd5,
        S_TX_WAIT_IDLE = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and falling-edge detect. Flops reset to 1 so a
    // released bus produces no spurious edge after reset.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_sync_clk;
    logic                   w_sync_data;
    logic                   w_fall;

    assign w_sync_clk  = r_clk_sync[SYNC_STAGES-1];
    assign w_sync_data = r_data_sync[SYNC_STAGES-1];
    assign w_fall      = r_clk_prev & ~w_sync_clk;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk_async_i};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data_async_i};
            r_clk_prev  <= w_sync_clk;
        end
    end

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;        // cycles since last falling edge / state entry
    logic [3:0]       r_bit_cnt;
    logic [9:0]       r_rx_bits;    // start..parity, start ends up in bit 0
    logic [9:0]       r_tx_frame;   // {stop, parity, data}, shifted out LSB first
    logic             r_ext;
    logic             r_brk;
    logic             r_push;
    logic [9:0]       r_push_data;
    logic             r_run;
    logic             r_rx_err;
    logic             r_tx_err;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             w_timeout;
    logic             w_rx_ok;
    logic [7:0]       w_rx_byte;

    assign w_timeout   = (r_state != S_IDLE) && (r_cnt == c_TO_LAST);
    assign w_rx_byte   = r_rx_bits[8:1];
    // start = 0, odd parity over data+parity, stop (current sample) = 1
    assign w_rx_ok     = ~r_rx_bits[0] & (^r_rx_bits[9:1]) & w_sync_data;
    assign cmd_ready_o = r_run && (r_state == S_IDLE) && !w_fall;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_rx_bits   <= '0;
            r_tx_frame  <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_run       <= 1'b0;
            r_rx_err    <= 1'b0;
            r_tx_err    <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
        end else begin
            r_run    <= 1'b1;
            r_push   <= 1'b0;
            r_rx_err <= 1'b0;
            r_tx_err <= 1'b0;

            // Our own clock pull during inhibit must not restart the count.
            if (r_state == S_IDLE || (w_fall && r_state != S_TX_INHIBIT))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + c_CW'(1);

            if (w_timeout) begin
                r_state   <= S_IDLE;
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
                if (r_state == S_RX) r_rx_err <= 1'b1;
                else                 r_tx_err <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_fall) begin
                            r_rx_bits <= {w_sync_data, r_rx_bits[9:1]};
                            r_bit_cnt <= 4'd1;
                            r_state   <= S_RX;
                        end else if (cmd_valid_i && r_run) begin
                            r_tx_frame <= {1'b1, ~^cmd_data_i, cmd_data_i};
                            r_clk_oe   <= 1'b1;
                            r_state    <= S_TX_INHIBIT;
                        end
                    end
                    S_RX: begin
                        if (w_fall) begin
                            if (r_bit_cnt == 4'd10) begin
                                r_state <= S_IDLE;
                                if (!w_rx_ok) begin
                                    r_rx_err <= 1'b1;
                                    r_ext    <= 1'b0;
                                    r_brk    <= 1'b0;
                                end else if (w_rx_byte == 8'hE0) begin
                                    r_ext <= 1'b1;
                                end else if (w_rx_byte == 8'hF0) begin
                                    r_brk <= 1'b1;
                                end else begin
                                    r_push      <= 1'b1;
                                    r_push_data <= {r_brk, r_ext, w_rx_byte};
                                    r_ext       <= 1'b0;
                                    r_brk       <= 1'b0;
                                end
                            end else begin
                                r_rx_bits <= {w_sync_data, r_rx_bits[9:1]};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_TX_INHIBIT: begin
                        if (r_cnt == c_INH_LAST) begin
                            r_data_oe <= 1'b1;   // start bit
                            r_cnt     <= '0;
                            r_state   <= S_TX_START;
                        end
                    end
                    S_TX_START: begin
                        r_clk_oe  <= 1'b0;       // hand the clock to the device
                        r_bit_cnt <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_TX_BITS;
                    end
                    S_TX_BITS: begin
                        if (w_fall) begin
                            r_data_oe  <= ~r_tx_frame[0];
                            r_tx_frame <= {1'b1, r_tx_frame[9:1]};
                            r_bit_cnt  <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd9) r_state <= S_TX_ACK;
                        end
                    end
                    S_TX_ACK: begin
                        if (w_fall) begin
                            if (w_sync_data) r_tx_err <= 1'b1;
                            r_state <= S_TX_WAIT_IDLE;
                        end
                    end
                    S_TX_WAIT_IDLE: begin
                        if (w_sync_clk && w_sync_data) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ps2_clk_oe_o  = r_clk_oe;
    assign ps2_data_oe_o = r_data_oe;
    assign rx_error_o    = r_rx_err;
    assign tx_error_o    = r_tx_err;

    // ------------------------------------------------------------------
    // Event FIFO with a registered head word.
    // ------------------------------------------------------------------
    logic [9:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_valid;
    logic [9:0]      r_head;
    logic            r_overflow;
    logic            r_irq;
    logic            w_pop;
    logic            w_full;
    logic            w_wr_en;
    logic            w_drop;
    logic [c_AW-1:0] w_rd_next;
    logic [c_AW:0]   w_count_next;
    logic            w_ovf_next;
    logic [9:0]      w_head_next;

    assign w_pop     = read_enable_i & r_valid;
    assign w_full    = (r_count == c_DEPTH);
    // A full FIFO still accepts a push when the same cycle pops.
    assign w_wr_en   = r_push & (~w_full | w_pop);
    assign w_drop    = r_push & w_full & ~w_pop;
    assign w_rd_next = w_pop ? r_rd_ptr + c_AW'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_en && !w_pop)      w_count_next = r_count + (c_AW+1)'(1);
        else if (!w_wr_en && w_pop) w_count_next = r_count - (c_AW+1)'(1);
    end

    assign w_ovf_next  = w_pop ? 1'b0 : (r_overflow | w_drop);
    // Bypass when the word being written becomes the new head.
    assign w_head_next = (w_wr_en && r_wr_ptr == w_rd_next) ? r_push_data
                                                            : r_mem[w_rd_next];

    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= r_push_data;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_count_next;
            r_valid    <= (w_count_next != '0);
            r_head     <= w_head_next;
            r_overflow <= w_ovf_next;
            r_irq      <= (w_count_next >= c_IRQ_TH) | w_ovf_next;
        end
    end

    assign read_data_o  = r_head;
    assign read_valid_o = r_valid;
    assign overflow_o   = r_overflow;
    assign interrupt_o  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_keyboard_host
// Purpose  : Self-checking bench for ps2_keyboard_host with a PS/2 device
//            model on open-drain lines and a queue of expected key events.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard_host;

    localparam int HALF = 20;   // device half bit period in clk cycles

    logic       clk = 1'b0;
    logic       reset_ni = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       read_enable = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;

    logic       ps2_clk_oe, ps2_data_oe;
    logic [9:0] read_data;
    logic       read_valid, interrupt, overflow, rx_error, cmd_ready, tx_error;
    logic       ps2_clk_line, ps2_data_line;

    always #5 clk = ~clk;

    // Open-drain wired-AND of device and host.
    assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_keyboard_host dut (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .ps2_clk_async_i  (ps2_clk_line),
        .ps2_data_async_i (ps2_data_line),
        .ps2_clk_oe_o     (ps2_clk_oe),
        .ps2_data_oe_o    (ps2_data_oe),
        .read_enable_i    (read_enable),
        .read_data_o      (read_data),
        .read_valid_o     (read_valid),
        .interrupt_o      (interrupt),
        .overflow_o       (overflow),
        .rx_error_o       (rx_error),
        .cmd_valid_i      (cmd_valid),
        .cmd_data_i       (cmd_data),
        .cmd_ready_o      (cmd_ready),
        .tx_error_o       (tx_error)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         rx_err_cnt = 0;
    int         tx_err_cnt = 0;
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (rx_error) rx_err_cnt++;
        if (tx_error) tx_err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Device-to-host: data changes while clock is high, host samples on fall.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_data = frame[i];
            cycles(HALF);
            dev_clk = 1'b0;
            cycles(HALF);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        cycles(HALF);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
    endtask

    task automatic pop_one(input string tag);
        int t;
        t = 0;
        while (!read_valid && t < 1000) begin cycles(1); t++; end
        chk({tag, " valid"}, {31'd0, read_valid}, 32'd1);
        chk({tag, " data"}, {22'd0, read_data},
            (exp_q.size() > 0) ? {22'd0, exp_q.pop_front()} : 32'hFFFF_FFFF);
        read_enable = 1'b1;
        cycles(1);
        read_enable = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_one(tag);
        chk({tag, " empty"}, {31'd0, read_valid}, 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int t;
        t = 0;
        while (!cmd_ready && t < 500) begin cycles(1); t++; end
        chk({tag, " back to idle"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    // Host-to-device: device clocks, reads on rising edge, optionally acks.
    task automatic do_tx(input logic [7:0] b, input logic ack,
                         output logic [10:0] seen, output int low_cycles);
        int t;
        cmd_data  = b;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 100) begin cycles(1); t++; end
        cycles(1);
        cmd_valid = 1'b0;
        t = 0;
        while (ps2_clk_line && t < 100) begin cycles(1); t++; end
        low_cycles = 0;
        while (!ps2_clk_line && low_cycles < 6000) begin cycles(1); low_cycles++; end
        cycles(10);
        seen = '0;
        seen[0] = ps2_data_line;
        for (int i = 1; i < 11; i++) begin
            dev_clk = 1'b0;
            cycles(HALF);
            dev_clk = 1'b1;
            seen[i] = ps2_data_line;
            cycles(HALF);
        end
        dev_data = ~ack;
        cycles(HALF);
        dev_clk = 1'b0;
        cycles(HALF);
        dev_clk = 1'b1;
        cycles(HALF);
        dev_data = 1'b1;
    endtask

    logic [10:0] seen;
    int          low;

    initial begin
        // Reset state
        cycles(5);
        chk("reset outputs",
            {15'd0, ps2_clk_oe, ps2_data_oe, read_valid, interrupt, overflow,
             rx_error, cmd_ready, tx_error, read_data}, 32'd0);
        reset_ni = 1'b1;
        cycles(2);
        chk("cmd_ready after reset", {31'd0, cmd_ready}, 32'd1);

        // Plain, break and extended-break events
        exp_q.push_back(10'h01C); send_key(8'h1C);
        exp_q.push_back(10'h21C); send_key(8'hF0); send_key(8'h1C);
        exp_q.push_back(10'h375); send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
        cycles(10);
        chk("irq with events", {31'd0, interrupt}, 32'd1);
        drain("prefix");
        chk("irq after drain", {31'd0, interrupt}, 32'd0);
        chk("no rx errors", rx_err_cnt, 32'd0);

        // Parity error, then a good frame
        send_bits(mk_frame(8'h33, 1'b1), 11);
        exp_q.push_back(10'h01C); send_key(8'h1C);
        drain("parity");
        chk("parity rx_error count", rx_err_cnt, 32'd1);

        // Frame aborted mid-way by timeout
        send_bits(mk_frame(8'h55, 1'b0), 5);
        cycles(10100);
        chk("timeout rx_error count", rx_err_cnt, 32'd2);
        chk("idle after timeout", {31'd0, cmd_ready}, 32'd1);
        exp_q.push_back(10'h04B); send_key(8'h4B);
        drain("after timeout");

        // Overflow: 17 events into 16 entries
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back({2'b00, 8'h10 + 8'(i)});
            send_key(8'h10 + 8'(i));
        end
        cycles(10);
        chk("overflow set", {31'd0, overflow}, 32'd1);
        chk("irq on overflow", {31'd0, interrupt}, 32'd1);
        pop_one("first after overflow");
        chk("overflow cleared by pop", {31'd0, overflow}, 32'd0);
        chk("exp left after pop", exp_q.size(), 32'd15);
        drain("overflow drain");

        // Transmit ED with acknowledge
        do_tx(8'hED, 1'b1, seen, low);
        chk("inhibit length ok", {31'd0, (low >= 5000 && low <= 5003)}, 32'd1);
        chk("tx bits", {21'd0, seen}, {21'd0, 1'b1, ~^8'hED, 8'hED, 1'b0});
        wait_ready("tx ack");
        chk("tx released lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("no tx_error on ack", tx_err_cnt, 32'd0);
        exp_q.push_back(10'h0FA); send_key(8'hFA);
        drain("device reply");

        // Transmit ED without acknowledge
        do_tx(8'hED, 1'b0, seen, low);
        wait_ready("tx nack");
        chk("tx_error on nack", tx_err_cnt, 32'd1);
        chk("rx errors unchanged", rx_err_cnt, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
